decoder_scan: RTL and testbench

Parametrised N-to-2^N decoder with registered one-hot outputs, selectable output polarity, global enable and an auto-scan mode. In scan mode an internal index steps through all outputs at a programmable rate. Used as the select/strobe generator for multiplexed displays and bus-select logic. Supersedes the fixed 2-to-4 NAND decoder.

---
 rtl/decoder_scan.sv | 72 +++++++
 tb/tb_decoder_scan.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/decoder_scan.sv
// N-to-2^N decoder with registered one-hot outputs, selectable polarity,
// output enable and an auto-scan mode stepping the index every DIV cycles.
module decoder_scan #(
  parameter int N          = 2,
  parameter int ACTIVE_LOW = 1,
  parameter int DIV        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              hold,
  input  logic [N-1:0]      sel,
  output logic [2**N-1:0]   d,
  output logic [N-1:0]      cur_idx,
  output logic              wrap
);

  localparam int M  = 2**N;
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] presc;
  logic          prev_mode;

  logic [PW-1:0] nxt_presc;
  logic [N-1:0]  nxt_idx;
  logic          nxt_wrap;
  logic [M-1:0]  one_hot;
  logic [M-1:0]  nxt_d;

  always_comb begin
    nxt_presc = presc;
    nxt_idx   = cur_idx;
    nxt_wrap  = 1'b0;
    if (!mode || !prev_mode) begin
      // direct mode and scan entry both load sel and restart the prescaler
      nxt_idx   = sel;
      nxt_presc = '0;
    end else if (!hold) begin
      if (presc == PW'(DIV - 1)) begin
        nxt_presc = '0;
        nxt_idx   = cur_idx + N'(1);
        nxt_wrap  = &cur_idx;
      end else begin
        nxt_presc = presc + PW'(1);
      end
    end
  end

  always_comb begin
    one_hot          = '0;
    one_hot[nxt_idx] = en;
    nxt_d            = (ACTIVE_LOW != 0) ? ~one_hot : one_hot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      prev_mode <= 1'b0;
      cur_idx   <= '0;
      wrap      <= 1'b0;
      d         <= (ACTIVE_LOW != 0) ? '1 : '0;
    end else begin
      presc     <= nxt_presc;
      prev_mode <= mode;
      cur_idx   <= nxt_idx;
      wrap      <= nxt_wrap;
      d         <= nxt_d;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: default instance (N=2, active-low, DIV=4)
// plus a second instance (N=3, active-high, DIV=1) sharing the control inputs.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst, en, mode, hold;
  logic [1:0] sel;
  logic [2:0] sel2;
  logic [3:0] d;
  logic [1:0] cur_idx;
  logic       wrap;
  logic [7:0] d2;
  logic [2:0] cur2;
  logic       wrap2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decoder_scan dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .hold(hold), .sel(sel),
    .d(d), .cur_idx(cur_idx), .wrap(wrap)
  );

  decoder_scan #(.N(3), .ACTIVE_LOW(0), .DIV(1)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .hold(hold), .sel(sel2),
    .d(d2), .cur_idx(cur2), .wrap(wrap2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_dir [4];
    int         exp_cur [30];
    logic [3:0] one4;
    logic [7:0] one8;
    logic [3:0] exp_d;

    exp_dir = '{4'hE, 4'hD, 4'hB, 4'h7};
    exp_cur = '{2,2,2,2, 3,3,3,3, 0,0,0,0, 1,1,1,1, 2,2,2,2,
                3,3,3,3, 0,0,0,0, 1,1};
    one4 = 4'b0001;
    one8 = 8'b0000_0001;

    // reset
    rst = 1'b1; en = 1'b1; mode = 1'b1; hold = 1'b0; sel = 2'd0; sel2 = 3'd0;
    tick();
    tick();
    chk("rst_d", 32'(d), 32'hF);
    chk("rst_cur", 32'(cur_idx), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_d2", 32'(d2), 32'h00);
    chk("rst_cur2", 32'(cur2), 32'd0);

    // direct decode
    rst = 1'b0; mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      tick();
      chk("dir_d", 32'(d), 32'(exp_dir[i]));
      chk("dir_cur", 32'(cur_idx), 32'(i));
      chk("dir_wrap", 32'(wrap), 32'd0);
    end

    // enable gating
    sel = 2'd2; en = 1'b1;
    tick();
    chk("en1_d", 32'(d), 32'hB);
    en = 1'b0;
    tick();
    chk("en0_d", 32'(d), 32'hF);
    chk("en0_cur", 32'(cur_idx), 32'd2);
    en = 1'b1;
    tick();
    chk("en1b_d", 32'(d), 32'hB);

    // scan from index 2 with wrap; sel changes and blanking mid-scan
    mode = 1'b1;
    for (int t = 0; t < 30; t++) begin
      if (t == 4)  sel = 2'd1;
      if (t == 12) en = 1'b0;
      if (t == 16) en = 1'b1;
      tick();
      exp_d = en ? ~(one4 << exp_cur[t]) : 4'hF;
      chk("scan_cur", 32'(cur_idx), 32'(exp_cur[t]));
      chk("scan_wrap", 32'(wrap), (t == 8 || t == 24) ? 32'd1 : 32'd0);
      chk("scan_d", 32'(d), 32'(exp_d));
    end

    // hold at cur_idx=1, prescaler=1
    hold = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      chk("hold_cur", 32'(cur_idx), 32'd1);
      chk("hold_d", 32'(d), 32'hD);
      chk("hold_wrap", 32'(wrap), 32'd0);
    end
    hold = 1'b0;
    tick();
    tick();
    chk("rel_cur_2cyc", 32'(cur_idx), 32'd1);
    tick();
    chk("rel_cur_adv", 32'(cur_idx), 32'd2);
    chk("rel_d_adv", 32'(d), 32'hB);

    // reset mid-scan at cur_idx=3
    for (int t = 0; t < 4; t++) tick();
    chk("pre_rst_cur", 32'(cur_idx), 32'd3);
    sel = 2'd3;
    rst = 1'b1;
    tick();
    chk("mid_rst_cur", 32'(cur_idx), 32'd0);
    chk("mid_rst_d", 32'(d), 32'hF);
    chk("mid_rst_wrap", 32'(wrap), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_entry", 32'(cur_idx), 32'd3);
    chk("post_rst_d", 32'(d), 32'h7);

    // active-high, N=3, DIV=1 walk
    mode = 1'b0; sel2 = 3'd5;
    tick();
    chk("d2_dir", 32'(d2), 32'h20);
    chk("d2_dir_cur", 32'(cur2), 32'd5);
    sel2 = 3'd0; mode = 1'b1;
    for (int t = 0; t < 17; t++) begin
      tick();
      chk("walk_cur", 32'(cur2), 32'(t % 8));
      chk("walk_d", 32'(d2), 32'(one8 << (t % 8)));
      chk("walk_wrap", 32'(wrap2), (t == 8 || t == 16) ? 32'd1 : 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
